// File: rtl/bch_gf5_pkg.sv
// GF(2^5) arithmetic helpers and shared types for the BCH(31,21) Chien-search corrector.
// Field generated by x^5+x^2+1 with alpha = 5'b00010.
package bch_gf5_pkg;

  localparam int          LP_M         = 5;
  localparam int          LP_N         = 31;
  localparam logic [4:0]  LP_PRIM_POLY = 5'b00101;

  typedef logic [LP_M-1:0] gf5_t;

  // alpha^-1 = alpha^4 + alpha, alpha^-2 = alpha^3 + 1
  localparam gf5_t ALPHA_INV  = 5'h12;
  localparam gf5_t ALPHA_INV2 = 5'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEARCH,
    ST_DONE
  } state_t;

  // Squaring is linear: sum a_i * alpha^(2i), with alpha^0,2,4,6,8 precomputed.
  function automatic gf5_t fn_gf5_sq(input gf5_t a);
    gf5_t r;
    r = '0;
    if (a[0]) r ^= 5'h01;
    if (a[1]) r ^= 5'h04;
    if (a[2]) r ^= 5'h10;
    if (a[3]) r ^= 5'h0A;
    if (a[4]) r ^= 5'h0D;
    return r;
  endfunction

  function automatic gf5_t fn_gf5_mul_alpha_inv(input gf5_t a);
    return {1'b0, a[4:1]} ^ (a[0] ? ALPHA_INV : 5'h00);
  endfunction

  function automatic gf5_t fn_gf5_mul_alpha_inv2(input gf5_t a);
    return {2'b00, a[4:2]} ^ (a[0] ? ALPHA_INV2 : 5'h00) ^ (a[1] ? ALPHA_INV : 5'h00);
  endfunction

endpackage

// File: rtl/bch_dec_chien_31_if.sv
// Handshake bundle of the BCH(31,21) corrector: syndrome/codeword in, corrected word out.
// Signal suffixes describe direction as seen by the corrector.
interface bch_dec_chien_31_if;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [9:0]  synd_i;
  logic [30:0] cw_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [30:0] data_o;
  logic [1:0]  n_err_o;
  logic        unc_o;

  modport slave (
    input  s_valid_i, synd_i, cw_i, m_ready_i,
    output s_ready_o, m_valid_o, data_o, n_err_o, unc_o
  );

  modport master (
    output s_valid_i, synd_i, cw_i, m_ready_i,
    input  s_ready_o, m_valid_o, data_o, n_err_o, unc_o
  );
endinterface

// File: rtl/bch_dec_chien_31_gf32_mul.sv
// Combinational general GF(2^5) multiplier (shift-and-add with on-the-fly reduction).
module gf32_mul
  import bch_gf5_pkg::*;
(
  input  gf5_t a,
  input  gf5_t b,
  output gf5_t p
);

  function automatic gf5_t fn_mul(input gf5_t x, input gf5_t y);
    gf5_t acc;
    gf5_t sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < LP_M; i++) begin
      if (y[i]) acc ^= sh;
      sh = {sh[3:0], 1'b0} ^ (sh[4] ? LP_PRIM_POLY : 5'h00);
    end
    return acc;
  endfunction

  assign p = fn_mul(a, b);

endmodule

// File: rtl/bch_dec_chien_31.sv
// DEC BCH(31,21) error locator/corrector: builds the division-free locator from {S3,S1}
// and runs a bit-serial Chien search over all 31 positions.
module bch_dec_chien_31
  import bch_gf5_pkg::*;
#(
  parameter int P_N = 31,
  parameter int P_M = 5
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  bch_dec_chien_31_if.slave   bus
);

  if (P_N != LP_N || P_M != LP_M) begin : g_param_check
    $error("bch_dec_chien_31 supports only P_N=31 and P_M=5");
  end

  localparam logic [4:0] LP_K_LAST = 5'(P_N - 1);

  state_t      state_q, state_d;
  logic [30:0] cw_q, cw_orig_q;
  gf5_t        s1_q, s3_q;
  gf5_t        r0_q, r1_q, r2_q;
  logic [4:0]  k_q;
  logic [1:0]  cnt_q, exp_q, n_err_q;
  logic        unc_q;

  gf5_t        s1_sq, s1_cu, r2_init;
  logic        root, k_last;
  logic [1:0]  cnt_nxt;

  assign s1_sq = fn_gf5_sq(s1_q);

  gf32_mul u_cube (
    .a (s1_q),
    .b (s1_sq),
    .p (s1_cu)
  );

  assign r2_init = s3_q ^ s1_cu;
  // Sum of the three scaled terms is sigma'(alpha^-k); zero marks an error at bit k.
  assign root    = ((r0_q ^ r1_q ^ r2_q) == 5'h00);
  assign k_last  = (k_q == LP_K_LAST);
  assign cnt_nxt = (root && cnt_q != 2'd3) ? cnt_q + 2'd1 : cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.s_valid_i)        state_d = ST_CALC;
      ST_CALC:   state_d = (s1_q == 5'h00) ? ST_DONE : ST_SEARCH;
      ST_SEARCH: if (k_last)               state_d = ST_DONE;
      ST_DONE:   if (bus.m_ready_i)        state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cw_q      <= '0;
      cw_orig_q <= '0;
      s1_q      <= '0;
      s3_q      <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      n_err_q   <= '0;
      unc_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.s_valid_i) begin
            cw_q      <= bus.cw_i;
            cw_orig_q <= bus.cw_i;
            s1_q      <= bus.synd_i[4:0];
            s3_q      <= bus.synd_i[9:5];
          end
        end
        ST_CALC: begin
          r0_q    <= s1_q;
          r1_q    <= s1_sq;
          r2_q    <= r2_init;
          k_q     <= '0;
          cnt_q   <= '0;
          n_err_q <= '0;
          unc_q   <= (s1_q == 5'h00) && (s3_q != 5'h00);
          exp_q   <= (r2_init == 5'h00) ? 2'd1 : 2'd2;
        end
        ST_SEARCH: begin
          r1_q  <= fn_gf5_mul_alpha_inv(r1_q);
          r2_q  <= fn_gf5_mul_alpha_inv2(r2_q);
          k_q   <= k_q + 5'd1;
          cnt_q <= cnt_nxt;
          cw_q  <= cw_q ^ ({30'b0, root} << k_q);
          if (k_last) begin
            // Root count disagreeing with the locator degree means more than two errors.
            if (cnt_nxt != exp_q) begin
              unc_q   <= 1'b1;
              n_err_q <= '0;
              cw_q    <= cw_orig_q;
            end else begin
              n_err_q <= cnt_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready_o = (state_q == ST_IDLE);
  assign bus.m_valid_o = (state_q == ST_DONE);
  assign bus.data_o    = cw_q;
  assign bus.n_err_o   = n_err_q;
  assign bus.unc_o     = unc_q;

endmodule
